// File: rtl/spi_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_slave_pkg: SPI register-slave frame layout, R/W encoding and states.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package spi_slave_pkg;

  localparam int c_FRAME_BITS   = 16;
  localparam int c_HDR_BITS     = 8;
  localparam int c_FRM_RW_BIT   = 15;
  localparam int c_FRM_ADDR_LSB = 8;
  localparam int c_HDR_RW_BIT   = c_FRM_RW_BIT - c_FRM_ADDR_LSB;
  localparam int c_ADDR_W       = 7;
  localparam logic c_RW_READ    = 1'b1;
  localparam logic c_RW_WRITE   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_WAIT_CS = 2'd3
  } spi_state_e;

  function automatic logic hdr_is_read(input logic [c_HDR_BITS-1:0] hdr);
    return hdr[c_HDR_RW_BIT] == c_RW_READ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_ff: two-flop synchronizer with a parameterized reset level.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sync_ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_sync <= {2{RST_VAL}};
    else       r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_slave_regs: SPI mode-3 slave giving read/write access to a register   |
// | file of NUM_REGS bytes.                 Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int                    NUM_REGS = 16,
  parameter logic [NUM_REGS*8-1:0] RST_VAL  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_t,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_stb_o,
  output logic [6:0]            wr_adr_o,
  output logic [7:0]            wr_dat_o,
  output logic                  frame_err_o
);

  logic w_cs_s, w_sck_s, w_mosi_s;

  sync_ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk_i(clk_i), .rst_i(rst_i), .i_d(spi_cs_i),   .o_q(w_cs_s));
  sync_ff #(.RST_VAL(1'b1)) u_sync_sck  (.clk_i(clk_i), .rst_i(rst_i), .i_d(spi_clk_i),  .o_q(w_sck_s));
  sync_ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i(clk_i), .rst_i(rst_i), .i_d(spi_mosi_i), .o_q(w_mosi_s));

  spi_state_e              r_state, w_state_nxt;
  logic [4:0]              r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                    r_cs_d, r_sck_d, r_armed;
  logic [1:0]              r_settle;
  logic [6:0]              r_shift;
  logic [7:0]              w_shift_nxt;
  logic                    r_rw;
  logic [c_ADDR_W-1:0]     r_addr;
  logic [NUM_REGS*8-1:0]   r_regs;
  logic [7:0]              r_miso_sr, w_rd_dat;
  logic                    r_miso_t, r_wr_stb, r_frame_err;
  logic [6:0]              r_wr_adr;
  logic [7:0]              r_wr_dat;
  logic                    w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
  logic                    w_last_bit, w_hdr_ld, w_commit, w_err;

  // A CS falling edge only counts once CS has been seen high after reset,
  // so a frame already in flight across reset is never picked up halfway.
  assign w_cs_fall   = r_armed & r_cs_d & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_d & w_cs_s;
  assign w_sck_rise  = ~r_sck_d & w_sck_s;
  assign w_sck_fall  = r_sck_d & ~w_sck_s;
  assign w_shift_nxt = {r_shift, w_mosi_s};
  assign w_cnt_inc   = (r_cnt == 5'h1F) ? r_cnt : r_cnt + 5'd1;

  always_comb begin
    w_rd_dat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_shift_nxt[6:0] == i[6:0]) w_rd_dat = r_regs[i*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hdr_ld    = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_last_bit  = w_sck_rise && (r_cnt == 5'(c_FRAME_BITS - 1));
    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ADDR;
          w_cnt_nxt   = '0;
        end
      end
      ST_ADDR: begin
        if (w_sck_rise) begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == 5'(c_HDR_BITS - 1)) begin
            w_hdr_ld    = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_sck_rise) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_last_bit) begin
            w_commit    = (r_rw == c_RW_WRITE) && (int'(r_addr) < NUM_REGS);
            w_state_nxt = ST_WAIT_CS;
          end
        end
      end
      ST_WAIT_CS: begin
        // Saturating count means the overrun flag fires on bit 17 only.
        if (w_sck_rise) begin
          w_cnt_nxt = w_cnt_inc;
          w_err     = (r_cnt == 5'(c_FRAME_BITS));
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
      w_hdr_ld    = 1'b0;
      if ((r_state == ST_ADDR) || ((r_state == ST_DATA) && !w_last_bit)) w_err = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cs_d      <= 1'b1;
      r_sck_d     <= 1'b1;
      r_settle    <= '0;
      r_armed     <= 1'b0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_regs      <= RST_VAL;
      r_miso_sr   <= '0;
      r_miso_t    <= 1'b1;
      r_wr_stb    <= 1'b0;
      r_wr_adr    <= '0;
      r_wr_dat    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_cs_d      <= w_cs_s;
      r_sck_d     <= w_sck_s;
      r_wr_stb    <= w_commit;
      r_frame_err <= w_err;
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      else if (w_cs_s)      r_armed  <= 1'b1;
      if (w_sck_rise && ((r_state == ST_ADDR) || (r_state == ST_DATA))) r_shift <= w_shift_nxt[6:0];
      if (w_commit) begin
        r_wr_adr <= r_addr;
        r_wr_dat <= w_shift_nxt;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_addr == i[6:0]) r_regs[i*8 +: 8] <= w_shift_nxt;
        end
      end
      // MSB is held through the falling edge that follows the header.
      if (w_hdr_ld) begin
        r_rw   <= w_shift_nxt[c_HDR_RW_BIT];
        r_addr <= w_shift_nxt[6:0];
        if (hdr_is_read(w_shift_nxt)) begin
          r_miso_sr <= w_rd_dat;
          r_miso_t  <= 1'b0;
        end
      end else if (w_sck_fall && (r_cnt > 5'd8) && (r_state != ST_IDLE)) begin
        r_miso_sr <= {r_miso_sr[6:0], 1'b0};
      end
      if (w_state_nxt == ST_IDLE) begin
        r_miso_t  <= 1'b1;
        r_miso_sr <= '0;
      end
    end
  end

  assign spi_miso_o  = r_miso_sr[7];
  assign spi_miso_t  = r_miso_t;
  assign regs_o      = r_regs;
  assign wr_stb_o    = r_wr_stb;
  assign wr_adr_o    = r_wr_adr;
  assign wr_dat_o    = r_wr_dat;
  assign frame_err_o = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_slave_regs: directed and random frames against a byte-array model. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_spi_slave_regs;

  localparam int         NR   = 16;
  localparam logic [127:0] RV = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

  logic         clk = 1'b0, rst = 1'b1;
  logic         cs = 1'b1, sck = 1'b1, mosi = 1'b0;
  logic         miso, miso_t, wr_stb, frame_err;
  logic [127:0] regs;
  logic [6:0]   wr_adr;
  logic [7:0]   wr_dat;

  int n_cmp = 0, n_bad = 0;
  int stb_cnt = 0, err_cnt = 0;
  logic [7:0] mregs [NR];
  logic [6:0] m_adr;
  logic [7:0] m_dat;

  spi_slave_regs #(.NUM_REGS(NR), .RST_VAL(RV)) dut (
    .clk_i(clk), .rst_i(rst), .spi_cs_i(cs), .spi_clk_i(sck), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_t(miso_t), .regs_o(regs), .wr_stb_o(wr_stb),
    .wr_adr_o(wr_adr), .wr_dat_o(wr_dat), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_stb)    stb_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] model_flat();
    logic [127:0] v = '0;
    for (int i = 0; i < NR; i++) v[i*8 +: 8] = mregs[i];
    return v;
  endfunction

  task automatic model_reset();
    logic [127:0] rv = RV;
    for (int i = 0; i < NR; i++) mregs[i] = rv[i*8 +: 8];
    m_adr = '0;
    m_dat = '0;
  endtask

  // Expected effect of one frame of nbits clocks, from the frame rules alone.
  task automatic model_frame(input logic [15:0] fr, input int nbits,
                             output logic [7:0] erx, output logic [15:0] etp,
                             output int estb, output int eerr);
    int a = int'(fr[14:8]);
    erx  = 8'h00;
    estb = 0;
    eerr = (nbits != 16) ? 1 : 0;
    etp  = fr[15] ? 16'h00FF : 16'hFFFF;
    for (int k = 0; k < 16; k++) if (k >= nbits) etp[k] = 1'b0;
    if (nbits >= 16) begin
      if (fr[15]) erx = (a < NR) ? mregs[a] : 8'h00;
      else if (a < NR) begin
        mregs[a] = fr[7:0];
        m_adr    = fr[14:8];
        m_dat    = fr[7:0];
        estb     = 1;
      end
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m, output logic t);
    sck  = 1'b0;
    mosi = b;
    repeat (5) @(posedge clk);
    #1;
    m   = miso;
    t   = miso_t;
    sck = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic cs_high();
    repeat (5) @(posedge clk);
    #1;
    cs = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [15:0] fr, input int nbits,
                      output logic [7:0] rx, output logic [15:0] tp);
    logic m, t;
    logic [16:0] bits;
    bits = {fr, 1'b1};
    rx = '0;
    tp = '0;
    cs_low();
    for (int k = 0; k < nbits; k++) begin
      spi_bit(bits[16-k], m, t);
      if (k < 16) tp[k] = t;
      if (k >= 8 && k < 16) rx[15-k] = m;
    end
    cs_high();
  endtask

  task automatic test_reset();
    n_cmp++; if (regs !== RV) begin n_bad++; $display("FAIL reset_regs: got %h want %h", regs, RV); end
    n_cmp++; if ({miso, miso_t, wr_stb, frame_err} !== 4'b0100) begin n_bad++;
      $display("FAIL reset_bits: got miso=%b t=%b stb=%b err=%b want 0 1 0 0", miso, miso_t, wr_stb, frame_err); end
    n_cmp++; if ({wr_adr, wr_dat} !== 15'd0) begin n_bad++; $display("FAIL reset_wr: got adr=%h dat=%h want 0 0", wr_adr, wr_dat); end
  endtask

  task automatic test_single_write();
    logic [7:0] rx, erx; logic [15:0] tp, etp; int s0, e0, es, ee;
    s0 = stb_cnt; e0 = err_cnt;
    model_frame(16'h0302, 16, erx, etp, es, ee);
    xfer(16'h0302, 16, rx, tp);
    n_cmp++; if (regs[31:24] !== 8'h02) begin n_bad++; $display("FAIL wr_reg3: got %h want 02", regs[31:24]); end
    n_cmp++; if (stb_cnt - s0 !== 1) begin n_bad++; $display("FAIL wr_stb: got %0d want 1", stb_cnt - s0); end
    n_cmp++; if ({wr_adr, wr_dat} !== {7'd3, 8'h02}) begin n_bad++; $display("FAIL wr_adr_dat: got %h/%h want 03/02", wr_adr, wr_dat); end
    n_cmp++; if (err_cnt - e0 !== 0 || tp !== etp) begin n_bad++; $display("FAIL wr_err_t: got err=%0d t=%h want 0 %h", err_cnt - e0, tp, etp); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] frs [4] = '{16'h0100, 16'h020D, 16'h0302, 16'h0400};
    logic [7:0] rx, erx; logic [15:0] tp, etp; int s0, es, ee;
    s0 = stb_cnt;
    foreach (frs[i]) begin
      model_frame(frs[i], 16, erx, etp, es, ee);
      xfer(frs[i], 16, rx, tp);
    end
    n_cmp++; if (regs[39:8] !== 32'h00_02_0D_00) begin n_bad++; $display("FAIL b2b_regs: got %h want 00020d00", regs[39:8]); end
    n_cmp++; if (stb_cnt - s0 !== 4) begin n_bad++; $display("FAIL b2b_stb: got %0d want 4", stb_cnt - s0); end
  endtask

  task automatic test_read();
    logic [7:0] rx, erx; logic [15:0] tp, etp; int s0, es, ee;
    model_frame(16'h02A5, 16, erx, etp, es, ee);
    xfer(16'h02A5, 16, rx, tp);
    s0 = stb_cnt;
    model_frame(16'h8200, 16, erx, etp, es, ee);
    xfer(16'h8200, 16, rx, tp);
    n_cmp++; if (rx !== 8'hA5) begin n_bad++; $display("FAIL rd_data: got %h want a5", rx); end
    n_cmp++; if (tp !== 16'h00FF) begin n_bad++; $display("FAIL rd_tristate: got %h want 00ff", tp); end
    n_cmp++; if ({miso, miso_t} !== 2'b01) begin n_bad++; $display("FAIL rd_idle: got miso=%b t=%b want 0 1", miso, miso_t); end
    n_cmp++; if (stb_cnt != s0 || regs !== model_flat()) begin n_bad++; $display("FAIL rd_noside: got stb=%0d regs=%h want 0 %h", stb_cnt - s0, regs, model_flat()); end
  endtask

  task automatic test_abort();
    logic [7:0] rx, erx; logic [15:0] tp, etp; int e0, es, ee;
    e0 = err_cnt;
    model_frame(16'h0577, 11, erx, etp, es, ee);
    xfer(16'h0577, 11, rx, tp);
    n_cmp++; if (regs[47:40] !== mregs[5]) begin n_bad++; $display("FAIL abort_reg5: got %h want %h", regs[47:40], mregs[5]); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL abort_err: got %0d want 1", err_cnt - e0); end
    model_frame(16'h0577, 16, erx, etp, es, ee);
    xfer(16'h0577, 16, rx, tp);
    n_cmp++; if (regs[47:40] !== 8'h77) begin n_bad++; $display("FAIL abort_next: got %h want 77", regs[47:40]); end
  endtask

  task automatic test_overrun();
    logic [7:0] rx, erx; logic [15:0] tp, etp; int e0, es, ee;
    e0 = err_cnt;
    model_frame(16'h0611, 17, erx, etp, es, ee);
    xfer(16'h0611, 17, rx, tp);
    n_cmp++; if (regs[55:48] !== 8'h11) begin n_bad++; $display("FAIL ovr_reg6: got %h want 11", regs[55:48]); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL ovr_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rx, erx; logic [15:0] tp, etp; int s0, e0, es, ee;
    s0 = stb_cnt; e0 = err_cnt;
    model_frame(16'h7F55, 16, erx, etp, es, ee);
    xfer(16'h7F55, 16, rx, tp);
    model_frame(16'hFF00, 16, erx, etp, es, ee);
    xfer(16'hFF00, 16, rx, tp);
    n_cmp++; if (regs !== model_flat()) begin n_bad++; $display("FAIL oor_regs: got %h want %h", regs, model_flat()); end
    n_cmp++; if (stb_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin n_bad++; $display("FAIL oor_pulses: got stb=%0d err=%0d want 0 0", stb_cnt - s0, err_cnt - e0); end
    n_cmp++; if (rx !== 8'h00) begin n_bad++; $display("FAIL oor_read: got %h want 00", rx); end
  endtask

  task automatic test_reset_midframe();
    logic [16:0] bits = {16'h8300, 1'b0};
    logic [7:0] rx, erx; logic [15:0] tp, etp; logic m, t; int s0, e0, es, ee;
    cs_low();
    for (int k = 0; k < 10; k++) spi_bit(bits[16-k], m, t);
    n_cmp++; if (miso_t !== 1'b0) begin n_bad++; $display("FAIL mid_pre_t: got %b want 0", miso_t); end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++; if (regs !== RV || {miso, miso_t, wr_stb, frame_err, wr_adr, wr_dat} !== {4'b0100, 15'd0}) begin n_bad++;
      $display("FAIL mid_rst_vals: got regs=%h miso=%b t=%b stb=%b err=%b adr=%h dat=%h want reset values", regs, miso, miso_t, wr_stb, frame_err, wr_adr, wr_dat); end
    rst = 1'b0;
    s0 = stb_cnt; e0 = err_cnt;
    for (int k = 10; k < 16; k++) spi_bit(bits[16-k], m, t);
    cs_high();
    n_cmp++; if (stb_cnt - s0 !== 0 || err_cnt - e0 !== 0 || regs !== RV) begin n_bad++;
      $display("FAIL mid_discard: got stb=%0d err=%0d regs=%h want 0 0 %h", stb_cnt - s0, err_cnt - e0, regs, RV); end
    model_frame(16'h0942, 16, erx, etp, es, ee);
    xfer(16'h0942, 16, rx, tp);
    n_cmp++; if (regs !== model_flat() || stb_cnt - s0 !== 1) begin n_bad++;
      $display("FAIL mid_next: got regs=%h stb=%0d want %h 1", regs, stb_cnt - s0, model_flat()); end
  endtask

  task automatic test_random();
    logic [7:0] rx, erx; logic [15:0] fr, tp, etp; int s0, e0, es, ee, nb;
    for (int n = 0; n < 40; n++) begin
      fr[15]   = $urandom_range(0, 2) == 0;
      fr[14:8] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 15));
      fr[7:0]  = 8'($urandom);
      case ($urandom_range(0, 9))
        0: nb = 5;
        1: nb = 12;
        2: nb = 17;
        default: nb = 16;
      endcase
      s0 = stb_cnt; e0 = err_cnt;
      model_frame(fr, nb, erx, etp, es, ee);
      xfer(fr, nb, rx, tp);
      n_cmp++;
      if (regs !== model_flat() || stb_cnt - s0 !== es || err_cnt - e0 !== ee || tp !== etp ||
          (nb >= 16 && fr[15] && rx !== erx) || (es == 1 && {wr_adr, wr_dat} !== {m_adr, m_dat})) begin
        n_bad++;
        $display("FAIL rand_%0d fr=%h nb=%0d: got regs=%h stb=%0d err=%0d t=%h rx=%h adr=%h dat=%h want %h %0d %0d %h %h %h %h",
                 n, fr, nb, regs, stb_cnt - s0, err_cnt - e0, tp, rx, wr_adr, wr_dat,
                 model_flat(), es, ee, etp, erx, m_adr, m_dat);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    test_single_write();
    test_back_to_back();
    test_read();
    test_abort();
    test_overrun();
    test_out_of_range();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
